// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
package regfile_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LCD = 1'b1;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester, clear and register-file port bundle for regfile_arbiter.
interface regfile_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              lcd_req;
    logic [ADDR_W-1:0] lcd_addr;
    logic              lcd_gnt;
    logic              lcd_rvalid;
    logic [DATA_W-1:0] lcd_rdata;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output lcd_req, lcd_addr, clear_req, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  lcd_gnt, lcd_rvalid, lcd_rdata,
        input  clear_busy, clear_done, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  lcd_req, lcd_addr, clear_req, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output lcd_gnt, lcd_rvalid, lcd_rdata,
        output clear_busy, clear_done, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/arb2_picker.sv
// Two-way winner select. REGFILE_ARB_RR_EN selects round-robin on contention
// (rr_ptr names the requester holding priority); otherwise CPU beats LCD.
module arb2_picker
    import regfile_arb_pkg::*;
(
`ifdef REGFILE_ARB_RR_EN
    input  logic rr_ptr,
`endif
    input  logic cpu_req,
    input  logic lcd_req,
    output logic req_valid,
    output logic winner
);

    // Winner select; only a double request consults the priority scheme
    always_comb begin
        req_valid = cpu_req | lcd_req;
        winner    = REQ_CPU;
        if (cpu_req && lcd_req) begin
`ifdef REGFILE_ARB_RR_EN
            winner = rr_ptr;
`else
            winner = REQ_CPU;
`endif
        end else if (lcd_req) begin
            winner = REQ_LCD;
        end else begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises CPU, LCD and clear-sweep accesses onto the single register-file port.
// Optional macro REGFILE_ARB_RR_EN: round-robin on CPU/LCD contention.
module regfile_arbiter
    import regfile_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    regfile_arbiter_if.slave bus
);

    localparam int ADDR_W = ADDR_W_DEF;
    localparam int DATA_W = DATA_W_DEF;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    arb_state_e        state_r,      state_nx_s;
    logic              pending_r,    pending_nx_s;
    logic [ADDR_W-1:0] clr_addr_r,   clr_addr_nx_s;
    logic              rd1_vld_r,    rd1_vld_nx_s;
    logic              rd1_who_r,    rd1_who_nx_s;
    logic              rd2_vld_r,    rd2_vld_nx_s;
    logic              rd2_who_r,    rd2_who_nx_s;
    logic              cpu_gnt_r,    cpu_gnt_nx_s;
    logic              lcd_gnt_r,    lcd_gnt_nx_s;
    logic              cpu_rvalid_r, cpu_rvalid_nx_s;
    logic              lcd_rvalid_r, lcd_rvalid_nx_s;
    logic [DATA_W-1:0] cpu_rdata_r,  cpu_rdata_nx_s;
    logic [DATA_W-1:0] lcd_rdata_r,  lcd_rdata_nx_s;
    logic [ADDR_W-1:0] mem_addr_r,   mem_addr_nx_s;
    logic              mem_we_r,     mem_we_nx_s;
    logic [DATA_W-1:0] mem_wdata_r,  mem_wdata_nx_s;
    logic              clear_busy_r, clear_busy_nx_s;
    logic              clear_done_r, clear_done_nx_s;
    logic              req_valid_s;
    logic              winner_s;
`ifdef REGFILE_ARB_RR_EN
    logic              rr_ptr_r,     rr_ptr_nx_s;
`endif

    arb2_picker u_picker (
`ifdef REGFILE_ARB_RR_EN
        .rr_ptr    (rr_ptr_r),
`endif
        .cpu_req   (bus.cpu_req),
        .lcd_req   (bus.lcd_req),
        .req_valid (req_valid_s),
        .winner    (winner_s)
    );

    // Next-state and next-output logic for the ARB/ISSUE/CLEAR sequencer
    always_comb begin
        state_nx_s      = state_r;
        clr_addr_nx_s   = clr_addr_r;
        rd1_vld_nx_s    = 1'b0;
        rd1_who_nx_s    = rd1_who_r;
        cpu_gnt_nx_s    = 1'b0;
        lcd_gnt_nx_s    = 1'b0;
        mem_addr_nx_s   = {ADDR_W{1'b0}};
        mem_we_nx_s     = 1'b0;
        mem_wdata_nx_s  = {DATA_W{1'b0}};
        clear_busy_nx_s = 1'b0;
        clear_done_nx_s = 1'b0;
`ifdef REGFILE_ARB_RR_EN
        rr_ptr_nx_s     = rr_ptr_r;
`endif
        if (bus.clear_req && (state_r != ST_CLEAR)) begin
            pending_nx_s = 1'b1;
        end else begin
            pending_nx_s = pending_r;
        end

        case (state_r)
            ST_ARB: begin
                // A clear_req seen this edge starts the sweep without an extra ARB cycle
                if (pending_r || bus.clear_req) begin
                    state_nx_s      = ST_CLEAR;
                    clr_addr_nx_s   = {ADDR_W{1'b0}};
                    mem_we_nx_s     = 1'b1;
                    clear_busy_nx_s = 1'b1;
                end else if (req_valid_s) begin
                    state_nx_s   = ST_ISSUE;
                    rd1_who_nx_s = winner_s;
`ifdef REGFILE_ARB_RR_EN
                    rr_ptr_nx_s  = ~winner_s;
`endif
                    if (winner_s == REQ_LCD) begin
                        lcd_gnt_nx_s  = 1'b1;
                        mem_addr_nx_s = bus.lcd_addr;
                        rd1_vld_nx_s  = 1'b1;
                    end else begin
                        cpu_gnt_nx_s   = 1'b1;
                        mem_addr_nx_s  = bus.cpu_addr;
                        mem_we_nx_s    = bus.cpu_we;
                        mem_wdata_nx_s = bus.cpu_we ? bus.cpu_wdata : {DATA_W{1'b0}};
                        rd1_vld_nx_s   = ~bus.cpu_we;
                    end
                end else begin
                    state_nx_s = ST_ARB;
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_ARB;
            end
            ST_CLEAR: begin
                if (clr_addr_r == CLR_LAST) begin
                    state_nx_s      = ST_ARB;
                    clr_addr_nx_s   = {ADDR_W{1'b0}};
                    pending_nx_s    = 1'b0;
                    clear_done_nx_s = 1'b1;
                end else begin
                    clr_addr_nx_s   = clr_addr_r + ADDR_W'(1);
                    mem_addr_nx_s   = clr_addr_r + ADDR_W'(1);
                    mem_we_nx_s     = 1'b1;
                    clear_busy_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_ARB;
            end
        endcase
    end

    // Read-return pipeline: data arrives the cycle after ISSUE, presented one later
    always_comb begin
        rd2_vld_nx_s    = rd1_vld_r;
        rd2_who_nx_s    = rd1_who_r;
        cpu_rvalid_nx_s = rd2_vld_r && (rd2_who_r == REQ_CPU);
        lcd_rvalid_nx_s = rd2_vld_r && (rd2_who_r == REQ_LCD);
        if (cpu_rvalid_nx_s) begin
            cpu_rdata_nx_s = bus.mem_rdata;
        end else begin
            cpu_rdata_nx_s = cpu_rdata_r;
        end
        if (lcd_rvalid_nx_s) begin
            lcd_rdata_nx_s = bus.mem_rdata;
        end else begin
            lcd_rdata_nx_s = lcd_rdata_r;
        end
    end

    // State, bookkeeping and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_ARB;
            pending_r    <= 1'b0;
            clr_addr_r   <= {ADDR_W{1'b0}};
            rd1_vld_r    <= 1'b0;
            rd1_who_r    <= 1'b0;
            rd2_vld_r    <= 1'b0;
            rd2_who_r    <= 1'b0;
            cpu_gnt_r    <= 1'b0;
            lcd_gnt_r    <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            lcd_rvalid_r <= 1'b0;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            lcd_rdata_r  <= {DATA_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= {DATA_W{1'b0}};
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
`ifdef REGFILE_ARB_RR_EN
            rr_ptr_r     <= REQ_CPU;
`endif
        end else begin
            state_r      <= state_nx_s;
            pending_r    <= pending_nx_s;
            clr_addr_r   <= clr_addr_nx_s;
            rd1_vld_r    <= rd1_vld_nx_s;
            rd1_who_r    <= rd1_who_nx_s;
            rd2_vld_r    <= rd2_vld_nx_s;
            rd2_who_r    <= rd2_who_nx_s;
            cpu_gnt_r    <= cpu_gnt_nx_s;
            lcd_gnt_r    <= lcd_gnt_nx_s;
            cpu_rvalid_r <= cpu_rvalid_nx_s;
            lcd_rvalid_r <= lcd_rvalid_nx_s;
            cpu_rdata_r  <= cpu_rdata_nx_s;
            lcd_rdata_r  <= lcd_rdata_nx_s;
            mem_addr_r   <= mem_addr_nx_s;
            mem_we_r     <= mem_we_nx_s;
            mem_wdata_r  <= mem_wdata_nx_s;
            clear_busy_r <= clear_busy_nx_s;
            clear_done_r <= clear_done_nx_s;
`ifdef REGFILE_ARB_RR_EN
            rr_ptr_r     <= rr_ptr_nx_s;
`endif
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_r;
    assign bus.lcd_gnt    = lcd_gnt_r;
    assign bus.cpu_rvalid = cpu_rvalid_r;
    assign bus.lcd_rvalid = lcd_rvalid_r;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.lcd_rdata  = lcd_rdata_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.clear_busy = clear_busy_r;
    assign bus.clear_done = clear_done_r;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural synchronous register file.
module tb_regfile_arbiter;
    import regfile_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic          who;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } gnt_exp_t;

    typedef struct packed {
        logic          who;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   clr_writes = 0;
    int   clr_done_cnt = 0;
    int   clr_exp_addr = 0;
    int   first_clr_cyc = 0;
    int   last_done_cyc = 0;

    gnt_exp_t      gnt_q[$];
    rd_exp_t       rd_q[$];
    int            rd_gnt_cyc_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] mem [DEPTH] = '{default: 16'h0000};

    always #10 clk = ~clk;

    regfile_arbiter_if bus ();

    regfile_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {5'd0, bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata, bus.lcd_gnt, bus.lcd_rvalid,
                bus.lcd_rdata, bus.clear_busy, bus.clear_done, bus.mem_addr, bus.mem_we, bus.mem_wdata};
    endfunction

    // Output monitor: pops scoreboard entries as grants and read data appear
    always @(negedge clk) begin
        gnt_exp_t g;
        rd_exp_t  r;
        int       gc;
        if (reset_n) begin
            if (bus.cpu_gnt || bus.lcd_gnt) begin
                check_eq("gnt_expected", gnt_q.size() > 0, 1'b1);
                if (gnt_q.size() > 0) begin
                    g = gnt_q.pop_front();
                    check_eq("gnt_who", {bus.cpu_gnt, bus.lcd_gnt}, g.who ? 2'b01 : 2'b10);
                    check_eq("gnt_mem_addr", bus.mem_addr, g.addr);
                    check_eq("gnt_mem_we", bus.mem_we, g.we);
                    check_eq("gnt_mem_wdata", bus.mem_wdata, g.wdata);
                    if (!g.we) rd_gnt_cyc_q.push_back(cyc);
                end
            end else if (bus.mem_we && !bus.clear_busy) begin
                check_eq("stray_mem_we", bus.mem_we, 1'b0);
            end
            if (bus.clear_busy) begin
                if (clr_exp_addr == 0) first_clr_cyc = cyc;
                check_eq("clr_we", bus.mem_we, 1'b1);
                check_eq("clr_wdata", bus.mem_wdata, 16'h0000);
                check_eq("clr_addr", bus.mem_addr, clr_exp_addr);
                clr_exp_addr++;
                clr_writes++;
            end else begin
                clr_exp_addr = 0;
            end
            if (bus.clear_done) begin
                clr_done_cnt++;
                last_done_cyc = cyc;
            end
            if (bus.cpu_rvalid || bus.lcd_rvalid) begin
                check_eq("rvalid_expected", rd_q.size() > 0, 1'b1);
                if (rd_q.size() > 0 && rd_gnt_cyc_q.size() > 0) begin
                    r  = rd_q.pop_front();
                    gc = rd_gnt_cyc_q.pop_front();
                    check_eq("rvalid_who", {bus.cpu_rvalid, bus.lcd_rvalid}, r.who ? 2'b01 : 2'b10);
                    check_eq("rdata", r.who ? bus.lcd_rdata : bus.cpu_rdata, r.data);
                    check_eq("rvalid_latency", cyc - gc, 2);
                end
            end
        end
    end

    task automatic access(input logic who, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit chk_lat);
        gnt_exp_t g;
        rd_exp_t  r;
        int       n;
        @(negedge clk);
        g.who = who; g.addr = a; g.we = we; g.wdata = we ? d : 16'h0000;
        gnt_q.push_back(g);
        if (we) begin
            ref_mem[a] = d;
        end else begin
            r.who = who; r.data = ref_mem[a];
            rd_q.push_back(r);
        end
        if (who == REQ_CPU) begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end else begin
            bus.lcd_req = 1'b1; bus.lcd_addr = a;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.cpu_gnt || bus.lcd_gnt) && n < 64);
        check_eq("gnt_seen", bus.cpu_gnt | bus.lcd_gnt, 1'b1);
        if (chk_lat) check_eq("gnt_latency", n, 1);
        bus.cpu_req = 1'b0;
        bus.lcd_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((gnt_q.size() > 0 || rd_q.size() > 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_gnt_q", gnt_q.size(), 0);
        check_eq("drain_rd_q", rd_q.size(), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, base_w, base_d, req_cyc, gnt_cyc;
        gnt_exp_t g;
        rd_exp_t  r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        reset_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 4'd0; bus.cpu_wdata = 16'h0000;
        bus.lcd_req = 1'b0; bus.lcd_addr = 4'd0; bus.clear_req = 1'b0;

        // Reset with random inputs: every output held at zero
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.cpu_req = 1'($urandom); bus.cpu_we = 1'($urandom); bus.cpu_addr = 4'($urandom);
            bus.cpu_wdata = 16'($urandom); bus.lcd_req = 1'($urandom); bus.lcd_addr = 4'($urandom);
            bus.clear_req = 1'($urandom);
            #1 check_eq("reset_outputs", all_outs(), 64'd0);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.lcd_req = 1'b0; bus.clear_req = 1'b0; bus.cpu_we = 1'b0;
        reset_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_gnt || bus.lcd_gnt || bus.clear_busy) n++;
        end
        check_eq("idle_no_activity", n, 0);

        // CPU write then LCD read of the same register
        access(REQ_CPU, 1'b1, 4'd3, 16'h00A5, 1'b1);
        access(REQ_LCD, 1'b0, 4'd3, 16'h0000, 1'b1);
        access(REQ_CPU, 1'b1, 4'd5, 16'h5555, 1'b1);
        access(REQ_CPU, 1'b1, 4'd10, 16'hAAAA, 1'b1);
        access(REQ_CPU, 1'b0, 4'd3, 16'h0000, 1'b1);
        access(REQ_LCD, 1'b0, 4'd15, 16'h0000, 1'b1);
        drain();

        // Contention: both requesters held for 8 grants
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
`ifdef REGFILE_ARB_RR_EN
            g.who = 1'(i % 2);
`else
            g.who = REQ_CPU;
`endif
            g.addr = g.who ? 4'd10 : 4'd5; g.we = 1'b0; g.wdata = 16'h0000;
            gnt_q.push_back(g);
            r.who = g.who; r.data = ref_mem[g.addr];
            rd_q.push_back(r);
        end
        bus.cpu_we = 1'b0; bus.cpu_addr = 4'd5; bus.lcd_addr = 4'd10;
        bus.cpu_req = 1'b1; bus.lcd_req = 1'b1;
        k = 0; n = 0;
        while (k < 8 && n < 64) begin
            @(negedge clk);
            n++;
            if (bus.cpu_gnt || bus.lcd_gnt) k++;
        end
        bus.cpu_req = 1'b0; bus.lcd_req = 1'b0;
        check_eq("contention_grants", k, 8);
        drain();

        // Clear and CPU write requested together: clear sweeps first
        @(negedge clk);
        base_w = clr_writes; base_d = clr_done_cnt;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        g.who = REQ_CPU; g.addr = 4'd9; g.we = 1'b1; g.wdata = 16'h1234;
        gnt_q.push_back(g);
        ref_mem[9] = 16'h1234;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'd9; bus.cpu_wdata = 16'h1234;
        bus.clear_req = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        bus.clear_req = 1'b0;
        n = 1;
        while (!bus.cpu_gnt && n < 64) begin
            @(negedge clk);
            n++;
        end
        gnt_cyc = cyc;
        bus.cpu_req = 1'b0;
        check_eq("prio_gnt_seen", bus.cpu_gnt, 1'b1);
        check_eq("prio_first_clear", first_clr_cyc - req_cyc, 1);
        check_eq("prio_clear_writes", clr_writes - base_w, 16);
        check_eq("prio_clear_done_cnt", clr_done_cnt - base_d, 1);
        check_eq("prio_clear_done_cyc", last_done_cyc - req_cyc, 17);
        check_eq("prio_gnt_after_done", gnt_cyc - last_done_cyc, 1);
        drain();
        access(REQ_LCD, 1'b0, 4'd9, 16'h0000, 1'b1);
        access(REQ_LCD, 1'b0, 4'd3, 16'h0000, 1'b1);
        access(REQ_CPU, 1'b1, 4'd2, 16'h0BEE, 1'b1);
        access(REQ_CPU, 1'b1, 4'd12, 16'h0C0C, 1'b1);
        drain();

        // Reset in the middle of a clear sweep
        @(negedge clk);
        base_w = clr_writes; base_d = clr_done_cnt;
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        n = 0;
        while (!(bus.clear_busy && bus.mem_addr == 4'd7) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("midclr_reached_7", {bus.clear_busy, bus.mem_addr}, 5'h17);
        #2 reset_n = 1'b0;
        #1 check_eq("midclr_outputs_zero", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) ref_mem[i] = 16'h0000;
        repeat (30) @(negedge clk);
        check_eq("midclr_no_done", clr_done_cnt - base_d, 0);
        check_eq("midclr_writes", clr_writes - base_w, 8);
        access(REQ_CPU, 1'b0, 4'd2, 16'h0000, 1'b1);
        access(REQ_LCD, 1'b0, 4'd12, 16'h0000, 1'b1);
        access(REQ_LCD, 1'b0, 4'd7, 16'h0000, 1'b1);
        drain();

        // Second clear_req during a sweep is ignored
        @(negedge clk);
        base_w = clr_writes; base_d = clr_done_cnt;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        repeat (5) @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("rereq_clear_writes", clr_writes - base_w, 16);
        check_eq("rereq_clear_done", clr_done_cnt - base_d, 1);
        access(REQ_LCD, 1'b0, 4'd12, 16'h0000, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single access port of the 16x16 register file between the CPU execute/writeback path and the LCD display scanner, and owns a sequential clear sweep that zeroes every register. It sits between requesters and the register-file memory, serialising all accesses so that CPU writeback, display readback and CLEAR never collide on the port.

## Interface
- DATA_W, 16, register width
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU register address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle grant pulse
- cpu_rvalid  out  1  one-cycle read-data-valid pulse (reads only)
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
- lcd_req  in  1  display read request; held with lcd_addr until lcd_gnt
- lcd_addr  in  ADDR_W  display register address
- lcd_gnt  out  1  one-cycle grant pulse
- lcd_rvalid  out  1  one-cycle read-data-valid pulse
- lcd_rdata  out  DATA_W  read data, valid with lcd_rvalid
- clear_req  in  1  single-cycle pulse: zero all registers
- clear_busy  out  1  high for the duration of the sweep
- clear_done  out  1  one-cycle pulse after the last clear write
- mem_addr  out  ADDR_W  register-file address
- mem_we  out  1  register-file write enable
- mem_wdata  out  DATA_W  register-file write data
- mem_rdata  in  DATA_W  register-file read data, valid the cycle after mem_addr

## Operation
- All outputs are registered; reset value of every output is 0.
- States: ARB, ISSUE, CLEAR. Reset enters ARB.
- clear_req sets a clear_pending flag in ARB or ISSUE; clear_req is ignored during CLEAR.
- ARB:
  - If clear_pending, go to CLEAR. Clear has absolute priority; pending requesters wait.
  - Else, if any request, choose a winner and go to ISSUE.
  - Else stay in ARB.
- ISSUE (exactly one cycle):
  - Winner's gnt = 1.
  - mem_addr = winner address.
  - mem_we = cpu_we for the CPU, 0 for the LCD.
  - mem_wdata = cpu_wdata for CPU writes, else 0.
  - Return to ARB unconditionally.
  - Requests are not sampled in ISSUE, so the maximum rate is one grant per 2 cycles.
- Read return: mem_rdata is captured during the cycle after ISSUE and presented on the winner's rdata/rvalid in the following cycle. CPU writes produce no rvalid.
- CLEAR:
  - Counter clr_addr starts at 0.
  - Each cycle: mem_we = 1, mem_wdata = 0, mem_addr = clr_addr; then clr_addr increments.
  - clear_busy = 1 throughout.
  - After address DEPTH-1 (DEPTH cycles total), the counter wraps to 0, clear_pending clears, the block returns to ARB, and clear_done pulses during that first ARB cycle.
- A single requester is always granted. Both requesting: resolved per Configuration.
- Same-address CPU write and LCD read are serialised in grant order; the read returns the value in the register file at its ISSUE cycle.
- reset_n asserted at any point (including mid-CLEAR or mid-read):
  - All outputs go to 0 immediately.
  - clear_pending, clr_addr and the arbitration pointer are cleared; the pointer's next winner is CPU.
  - Any in-flight read is dropped (no rvalid); an interrupted clear is not resumed.

## Timing
- Request sampled at edge T (state ARB) -> gnt and mem_* driven during cycle T+1 (ISSUE).
- Read data: mem_rdata valid during T+2 -> rvalid/rdata during T+3, i.e. 2 cycles after gnt.
- Requester drops req the cycle after it sees gnt; the next grant can issue at T+3.
- clear_req sampled at edge T in ARB -> first clear write in T+1, last in T+DEPTH, clear_done in T+DEPTH+1.
- clear_req arriving during ISSUE: the ISSUE completes, then CLEAR starts from the following ARB.

## Configuration
- REGFILE_ARB_RR_EN defined: two-way round-robin. A 1-bit last-winner pointer gives priority to the requester not granted last.
- Undefined: fixed priority, CPU over LCD; the LCD may starve under continuous CPU requests (accepted).

## Structure
- Package regfile_arb_pkg:
  - state enum (ARB, ISSUE, CLEAR)
  - requester ID constants (REQ_CPU = 0, REQ_LCD = 1)
  - default DATA_W / ADDR_W
- Sub-module arb2_picker: combinational two-way winner select, round-robin or fixed per the macro. It takes the pointer and the requests and returns the winner. The pointer register stays in regfile_arbiter.

## Test plan
- Reset: hold reset_n = 0 with random inputs -> every output 0; after release, no grant without a request.
- CPU write then LCD read:
  - cpu_we = 1, addr 3, wdata 0x00A5 -> cpu_gnt 1 cycle later, with mem_we = 1, mem_addr = 3, mem_wdata = 0x00A5 for one cycle.
  - Then lcd_req addr 3 -> lcd_rdata = 0x00A5 with lcd_rvalid 2 cycles after lcd_gnt.
- Contention: cpu_req and lcd_req held high for 8 grants -> with REGFILE_ARB_RR_EN, grants alternate CPU, LCD, CPU, ...; without it, all 8 go to the CPU.
- Clear priority: clear_req and cpu_req in the same cycle:
  - 16 writes, mem_addr 0..15, mem_wdata 0, clear_busy high throughout.
  - clear_done pulse, then cpu_gnt.
- Reset mid-clear: assert reset_n at mem_addr = 7 -> outputs 0 at once; after release, state ARB, clear not resumed, no clear_done.
- Clear re-request: second clear_req pulsed during CLEAR -> exactly 16 clear writes and one clear_done.
